// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: issues one memory op per cycle and checks read data
// one cycle later. Define MBIST_STOP_ON_FAIL_EN to end the test at the first mismatch.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int CMD_WIDTH  = 4,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [CMD_WIDTH-1:0]  mem_cmd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [FCNT_WIDTH-1:0] fail_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic [2:0]            first_fail_elem
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;
  localparam logic [2:0]            LAST_ELEM = 3'd5;

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  ph_q, ph_d;
  logic                  gen_done_q, gen_done_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            op_elem_q, op_elem_d;
  logic                  chk_vld_q, chk_vld_d;
  logic [DATA_WIDTH-1:0] chk_exp_q, chk_exp_d;
  logic [ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
  logic [2:0]            chk_elem_q, chk_elem_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [ADDR_WIDTH-1:0] ffa_q, ffa_d;
  logic [2:0]            ffe_q, ffe_d;
  logic                  pass_q, pass_d;

  logic two_op, op_wr, op_down, op_ones, issue, mismatch;

  // Decode the op at the generator position: M0 = w0, M5 = r0, M1..M4 = read then write.
  always_comb begin
    two_op  = (elem_q != 3'd0) && (elem_q != LAST_ELEM);
    op_wr   = (elem_q == 3'd0) || (two_op && ph_q);
    op_down = (elem_q == 3'd3) || (elem_q == 3'd4);
    if (elem_q == 3'd1 || elem_q == 3'd3)      op_ones = op_wr;
    else if (elem_q == 3'd2 || elem_q == 3'd4) op_ones = !op_wr;
    else                                       op_ones = 1'b0;
  end

  assign mismatch = chk_vld_q && (mem_rdata != chk_exp_q);

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    idx_d      = idx_q;
    ph_d       = ph_q;
    gen_done_d = gen_done_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_elem_d  = op_elem_q;
    fcnt_d     = fcnt_q;
    ffa_d      = ffa_q;
    ffe_d      = ffe_q;
    pass_d     = pass_q;
    issue      = 1'b0;
    // The op on the bus this cycle becomes the compare context for next cycle's rdata.
    chk_vld_d  = (state_q == S_RUN) && !wr_q;
    chk_exp_d  = wdata_q;
    chk_addr_d = addr_q;
    chk_elem_d = op_elem_q;

    if (mismatch) begin
      if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
      if (fcnt_q == '0) begin
        ffa_d = chk_addr_q;
        ffe_d = chk_elem_q;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          issue   = 1'b1;
          fcnt_d  = '0;
          ffa_d   = '0;
          ffe_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (gen_done_q) state_d = S_DRAIN;
        else            issue   = 1'b1;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

`ifdef MBIST_STOP_ON_FAIL_EN
    if (mismatch) begin
      state_d   = S_DONE;
      issue     = 1'b0;
      chk_vld_d = 1'b0;
    end
`endif

    if (state_d == S_DONE && state_q != S_DONE) pass_d = (fcnt_d == '0);

    if (issue) begin
      wr_d      = op_wr;
      addr_d    = op_down ? ~idx_q : idx_q;
      wdata_d   = {DATA_WIDTH{op_ones}};
      op_elem_d = elem_q;
      if (two_op && !ph_q) begin
        ph_d = 1'b1;
      end else begin
        ph_d  = 1'b0;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          if (elem_q == LAST_ELEM) begin
            elem_d     = 3'd0;
            gen_done_d = 1'b1;
          end else begin
            elem_d = elem_q + 3'd1;
          end
        end
      end
    end

    // Generator always restarts from M0/address 0 on the next run.
    if (state_d != S_RUN) begin
      elem_d     = 3'd0;
      idx_d      = '0;
      ph_d       = 1'b0;
      gen_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      elem_q     <= 3'd0;
      idx_q      <= '0;
      ph_q       <= 1'b0;
      gen_done_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_elem_q  <= 3'd0;
      chk_vld_q  <= 1'b0;
      chk_exp_q  <= '0;
      chk_addr_q <= '0;
      chk_elem_q <= 3'd0;
      fcnt_q     <= '0;
      ffa_q      <= '0;
      ffe_q      <= 3'd0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      idx_q      <= idx_d;
      ph_q       <= ph_d;
      gen_done_q <= gen_done_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_elem_q  <= op_elem_d;
      chk_vld_q  <= chk_vld_d;
      chk_exp_q  <= chk_exp_d;
      chk_addr_q <= chk_addr_d;
      chk_elem_q <= chk_elem_d;
      fcnt_q     <= fcnt_d;
      ffa_q      <= ffa_d;
      ffe_q      <= ffe_d;
      pass_q     <= pass_d;
    end
  end

  assign mem_cmd         = {{(CMD_WIDTH-1){1'b0}}, wr_q};
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign fail_count      = fcnt_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_elem = ffe_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty 1-cycle memory, March C- reference model, scoreboard.
module tb_mbist_march_ctrl;
  localparam int DW = 8, AW = 4, CW = 4, FW = 4, N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, pass;
  logic [FW-1:0] fail_count;
  logic [AW-1:0] first_fail_addr;
  logic [2:0]    first_fail_elem;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_WIDTH(CW), .FCNT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_addr(first_fail_addr), .first_fail_elem(first_fail_elem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory under test with per-address stuck-at masks applied on read.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] sa0 [N];
  logic          scramble = 1'b0;
  always @(posedge clk) begin
    if (scramble) for (int i = 0; i < N; i++) mem[i] <= DW'($urandom);
    else if (mem_cmd[0]) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  typedef struct { int cyc; bit wr; int addr; int data; bit first; } op_t;
  typedef struct { int cyc; bit pass; int fcnt; int ffa; int ffe; } res_t;
  op_t  op_q[$];
  res_t res_q[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the six March C- elements and predict every op plus the final verdict.
  task automatic expect_run(input int t0);
    int rd_pat[6] = '{-1, 0, 1, 0, 1, 0};
    int wr_pat[6] = '{0, 1, 0, 1, 0, -1};
    logic [DW-1:0] m [N];
    int opn = 0, fails = 0, ffa = 0, ffe = 0, limit = 1 << 30;
    bit stopped = 0;
    res_t r;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        logic [DW-1:0] want, got, wd;
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (rd_pat[e] >= 0) begin
          want = (rd_pat[e] == 1) ? '1 : '0;
          got  = (m[a] | sa1[a]) & ~sa0[a];
          if (opn <= limit) begin
            op_q.push_back('{t0 + opn, 1'b0, a, int'(want), opn == 0});
            if (got !== want) begin
              if (fails == 0) begin ffa = a; ffe = e; end
              if (fails < (1 << FW) - 1) fails++;
`ifdef MBIST_STOP_ON_FAIL_EN
              if (!stopped) begin stopped = 1; limit = opn + 1; end
`endif
            end
          end
          opn++;
        end
        if (wr_pat[e] >= 0) begin
          wd = (wr_pat[e] == 1) ? '1 : '0;
          if (opn <= limit) op_q.push_back('{t0 + opn, 1'b1, a, int'(wd), opn == 0});
          m[a] = wd;
          opn++;
        end
      end
    end
    r.cyc  = stopped ? t0 + limit + 1 : t0 + opn + 1;
    r.pass = (fails == 0);
    r.fcnt = fails;
    r.ffa  = ffa;
    r.ffe  = ffe;
    res_q.push_back(r);
  endtask

  // Monitor: pops expected ops while busy, and the verdict when done rises.
  bit done_prev = 1'b0;
  always @(negedge clk) begin : mon
    op_t  e;
    res_t r;
    if (!rst) begin
      done_prev <= 1'b0;
    end else begin
      if (busy) begin
        if (op_q.size() > 0) begin
          e = op_q.pop_front();
          chk("op_cycle", cyc, e.cyc);
          chk("op_cmd", int'(mem_cmd), int'(e.wr));
          chk("op_addr", int'(mem_addr), e.addr);
          if (e.wr) chk("op_wdata", int'(mem_wdata), e.data);
          if (e.first) begin
            chk("run_start_done", int'(done), 0);
            chk("run_start_pass", int'(pass), 0);
            chk("run_start_fcnt", int'(fail_count), 0);
            chk("run_start_ffa", int'(first_fail_addr), 0);
            chk("run_start_ffe", int'(first_fail_elem), 0);
          end
        end else begin
          chk("drain_cmd", int'(mem_cmd), 0);
        end
      end else begin
        chk("idle_cmd", int'(mem_cmd), 0);
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          r = res_q.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("done_busy", int'(busy), 0);
          chk("pass", int'(pass), int'(r.pass));
          chk("fail_count", int'(fail_count), r.fcnt);
          chk("first_fail_addr", int'(first_fail_addr), r.ffa);
          chk("first_fail_elem", int'(first_fail_elem), r.ffe);
          chk("ops_left", op_q.size(), 0);
          op_q.delete();
        end
      end
      done_prev <= done;
    end
  end

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    chk("done_seen", int'(ok), 1);
    if (!ok) begin op_q.delete(); res_q.delete(); end
  endtask

  task automatic launch();
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    expect_run(cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int mid_start);
    launch();
    if (mid_start > 0) begin
      repeat (mid_start - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(400);
  endtask

  task automatic hold_done(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("done_held", int'(done), 1);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd"}, int'(mem_cmd), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_wdata"}, int'(mem_wdata), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_fcnt"}, int'(fail_count), 0);
    chk({tag, "_ffa"}, int'(first_fail_addr), 0);
    chk({tag, "_ffe"}, int'(first_fail_elem), 0);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin sa1[i] = '0; sa0[i] = '0; end
  endtask

  initial begin
    clear_faults();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run(0);                                   // fault-free
    hold_done($urandom_range(1, 4));

    sa1[5] = 8'h01;                           // stuck-at-1 bit0 at address 5
    run(0);
    clear_faults();

    launch();                                 // reset in the middle of a run
    repeat (49) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("midrun_reset");
    op_q.delete();
    res_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(0);

    run($urandom_range(2, 158));              // start during RUN is ignored
    run(0);                                   // start from DONE reruns with cleared results

    for (int i = 0; i < N; i++) sa1[i] = '1;  // every read of 0 fails: count saturates
    run(0);
    clear_faults();

    repeat (6) begin
      int nf;
      clear_faults();
      nf = $urandom_range(1, 3);
      repeat (nf) begin
        int a;
        logic [DW-1:0] b;
        a = $urandom_range(0, N - 1);
        b = DW'(1) << $urandom_range(0, DW - 1);
        if ($urandom_range(0, 1) == 1) sa1[a] = sa1[a] | b;
        else                           sa0[a] = sa0[a] | b;
      end
      run(0);
      hold_done($urandom_range(0, 2));
    end
    clear_faults();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
